// File: rtl/pipe_to_stream_pkg.sv
// pipe_to_stream_pkg: shared width helpers and build options for pipe_to_stream.
// Build option: PIPE_TO_STREAM_ERROR_STICKY_EN makes error_full sticky until reset.
`default_nettype none

package pipe_to_stream_pkg;

  // Level counter must be able to hold the value DEPTH itself.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

`ifdef PIPE_TO_STREAM_ERROR_STICKY_EN
  localparam bit ERROR_STICKY = 1'b1;
`else
  localparam bit ERROR_STICKY = 1'b0;
`endif

endpackage

`default_nettype wire

// File: rtl/pipe_to_stream_lane.sv
// pipe_to_stream_lane: one circular lane FIFO with level counter, accept flag
// and next-state free count.
`default_nettype none

module pipe_to_stream_lane
  import pipe_to_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int LW   = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             s_rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_vld,
  output logic             can_accept,
  output logic [LW-1:0]    free_nxt
);

  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [LW-1:0]    level_nxt;
  logic             pop;

  // Explicit wrap keeps non-power-of-two depths inside the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_vld     = (level != '0);
  assign pop        = rd_vld & rd_rdy;
  assign can_accept = (level < LW'(DEPTH)) | pop;
  assign rd_data    = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (wr_en && !pop) begin
      level_nxt = level + LW'(1);
    end else if (!wr_en && pop) begin
      level_nxt = level - LW'(1);
    end
  end

  assign free_nxt = LW'(DEPTH) - level_nxt;

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      level <= level_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && s_rst_n) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_to_stream.sv
// pipe_to_stream: fans a valid-only pipe word out to OUT_NB buffered valid/ready lanes.
// Build option: PIPE_TO_STREAM_ERROR_STICKY_EN holds error_full high until reset.
`default_nettype none

module pipe_to_stream
  import pipe_to_stream_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int OUT_NB   = 4,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 2
) (
  input  logic                          clk,
  input  logic                          s_rst_n,
  input  logic [OUT_NB*WIDTH-1:0]       in_data,
  input  logic                          in_avail,
  output logic [OUT_NB-1:0][WIDTH-1:0]  out_data,
  output logic [OUT_NB-1:0]             out_vld,
  input  logic [OUT_NB-1:0]             out_rdy,
  output logic                          almost_full,
  output logic                          error_full
);

  localparam int LW = lvl_w(DEPTH);

  logic [OUT_NB-1:0] accept;
  logic [LW-1:0]     free_nxt [OUT_NB];
  logic              all_accept;
  logic              wr_en;
  logic              drop;
  logic              afull_nxt;

  // Words are written to all lanes or none, so lanes never lose alignment.
  assign all_accept = &accept;
  assign wr_en      = in_avail & all_accept & s_rst_n;
  assign drop       = in_avail & ~all_accept;

  for (genvar i = 0; i < OUT_NB; i++) begin : g_lane
    pipe_to_stream_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk        (clk),
      .s_rst_n    (s_rst_n),
      .wr_data    (in_data[lane_lo(i, WIDTH) +: WIDTH]),
      .wr_en      (wr_en),
      .rd_rdy     (out_rdy[i]),
      .rd_data    (out_data[i]),
      .rd_vld     (out_vld[i]),
      .can_accept (accept[i]),
      .free_nxt   (free_nxt[i])
    );
  end

  always_comb begin
    afull_nxt = 1'b0;
    for (int i = 0; i < OUT_NB; i++) begin
      if (free_nxt[i] <= LW'(AFULL_TH)) begin
        afull_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      almost_full <= 1'b0;
      error_full  <= 1'b0;
    end else begin
      almost_full <= afull_nxt;
      error_full  <= ERROR_STICKY ? (error_full | drop) : drop;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_to_stream.sv
// tb_pipe_to_stream: table vectors, directed corner sequences and random traffic
// checked against a per-lane queue model of pipe_to_stream.
`default_nettype none

module tb_pipe_to_stream;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int TH = 2;

`ifdef PIPE_TO_STREAM_ERROR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   s_rst_n;
  logic [N*W-1:0]         in_data;
  logic                   in_avail;
  logic [N-1:0][W-1:0]    out_data;
  logic [N-1:0]           out_vld;
  logic [N-1:0]           out_rdy;
  logic                   almost_full;
  logic                   error_full;

  always #5 clk = ~clk;

  pipe_to_stream #(
    .WIDTH    (W),
    .OUT_NB   (N),
    .DEPTH    (D),
    .AFULL_TH (TH)
  ) dut (
    .clk         (clk),
    .s_rst_n     (s_rst_n),
    .in_data     (in_data),
    .in_avail    (in_avail),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .almost_full (almost_full),
    .error_full  (error_full)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] q [N][$];
  bit           m_afull;
  bit           m_err;
  bit           checking = 1'b0;

  logic [N-1:0]        obs_vld;
  logic [N-1:0][W-1:0] obs_data;
  logic                obs_afull;
  logic                obs_err;

  typedef struct {
    bit             rn;
    bit             av;
    logic [N*W-1:0] d;
    logic [N-1:0]   rdy;
    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    bit             ea;
    bit             ee;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] word(input int k);
    logic [N*W-1:0] w;
    for (int i = 0; i < N; i++) w[i*W +: W] = W'(k * 16 + i + 1);
    return w;
  endfunction

  // One clock: drive inputs, sample/compare before the edge, advance the model.
  task automatic cycle(input bit rn, input bit av, input logic [N*W-1:0] d,
                       input logic [N-1:0] rdy);
    bit           all_ok;
    logic [N-1:0] pop;
    s_rst_n  = rn;
    in_avail = av;
    in_data  = d;
    out_rdy  = rdy;
    @(negedge clk);
    obs_vld   = out_vld;
    obs_data  = out_data;
    obs_afull = almost_full;
    obs_err   = error_full;
    if (checking) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("model_vld[%0d]", i), 64'(out_vld[i]), 64'(q[i].size() != 0));
        if (q[i].size() != 0)
          chk($sformatf("model_data[%0d]", i), 64'(out_data[i]), 64'(q[i][0]));
      end
      chk("model_almost_full", 64'(almost_full), 64'(m_afull));
      chk("model_error_full", 64'(error_full), 64'(m_err));
    end
    if (!rn) begin
      for (int i = 0; i < N; i++) q[i].delete();
      m_afull = 1'b0;
      m_err   = 1'b0;
    end else begin
      all_ok = 1'b1;
      for (int i = 0; i < N; i++) begin
        pop[i] = rdy[i] && (q[i].size() != 0);
        if (!(q[i].size() < D || pop[i])) all_ok = 1'b0;
      end
      for (int i = 0; i < N; i++) if (pop[i]) void'(q[i].pop_front());
      if (av && all_ok) for (int i = 0; i < N; i++) q[i].push_back(d[i*W +: W]);
      m_err   = (STICKY & m_err) | (av & ~all_ok);
      m_afull = 1'b0;
      for (int i = 0; i < N; i++) if ((D - q[i].size()) <= TH) m_afull = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N*W-1:0] w4321;
    bit             av;
    logic [N-1:0]   rdy;

    w4321 = {32'd4, 32'd3, 32'd2, 32'd1};
    tbl[0] = '{1'b1, 1'b0, '0,    4'b1111, 4'b0000, '0,    1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, w4321, 4'b1111, 4'b0000, '0,    1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, '0,    4'b1111, 4'b1111, w4321, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, '0,    4'b1111, 4'b0000, '0,    1'b0, 1'b0};

    s_rst_n = 1'b0; in_avail = 1'b0; in_data = '0; out_rdy = '0;
    cycle(1'b0, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, word(99), '0);
    checking = 1'b1;

    for (int r = 0; r < 4; r++) begin
      cycle(tbl[r].rn, tbl[r].av, tbl[r].d, tbl[r].rdy);
      chk($sformatf("tbl%0d_vld", r), 64'(obs_vld), 64'(tbl[r].ev));
      for (int i = 0; i < N; i++)
        if (tbl[r].ev[i])
          chk($sformatf("tbl%0d_data[%0d]", r, i), 64'(obs_data[i]), 64'(tbl[r].ed[i*W +: W]));
      chk($sformatf("tbl%0d_afull", r), 64'(obs_afull), 64'(tbl[r].ea));
      chk($sformatf("tbl%0d_err", r), 64'(obs_err), 64'(tbl[r].ee));
    end

    // Overflow: lane 2 stalled, nine words pushed.
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b1, 1'b1, word(k), 4'b1011);
      if (k == 6) chk("afull_after_word5", 64'(obs_afull), 64'd0);
      if (k == 7) chk("afull_after_word6", 64'(obs_afull), 64'd1);
      if (k == 9) chk("err_before_drop", 64'(obs_err), 64'd0);
    end
    cycle(1'b1, 1'b0, '0, 4'b1011);
    chk("err_pulse", 64'(obs_err), 64'd1);
    cycle(1'b1, 1'b0, '0, 4'b1011);
    chk("err_after_pulse", 64'(obs_err), 64'(STICKY));

    // Full lane with simultaneous pop and push.
    cycle(1'b1, 1'b1, word(10), 4'b1111);
    cycle(1'b1, 1'b0, '0, 4'b1011);
    chk("simul_no_err", 64'(obs_err), 64'(STICKY));
    chk("simul_afull", 64'(obs_afull), 64'd1);
    chk("simul_lane2_head", 64'(obs_data[2]), 64'(word(2) >> (2 * W)) & 64'hFFFF_FFFF);
    cycle(1'b1, 1'b1, word(11), 4'b1011);
    cycle(1'b1, 1'b0, '0, 4'b1011);
    chk("level8_drop_err", 64'(obs_err), 64'd1);
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, '0, 4'b1111);
    chk("drained_vld", 64'(obs_vld), 64'd0);

    // Reset with five entries per lane and in_avail high.
    for (int k = 20; k < 25; k++) cycle(1'b1, 1'b1, word(k), 4'b0000);
    cycle(1'b0, 1'b1, word(30), 4'b0000);
    cycle(1'b1, 1'b0, '0, 4'b0000);
    chk("rst_vld", 64'(obs_vld), 64'd0);
    chk("rst_afull", 64'(obs_afull), 64'd0);
    chk("rst_err", 64'(obs_err), 64'd0);
    cycle(1'b1, 1'b1, word(40), 4'b1111);
    cycle(1'b1, 1'b0, '0, 4'b1111);
    chk("post_rst_vld", 64'(obs_vld), 64'hF);
    chk("post_rst_lane0", 64'(obs_data[0]), 64'(W'(40 * 16 + 1)));

    // Random traffic with an upstream that honours almost_full.
    for (int c = 0; c < 3000; c++) begin
      av  = !m_afull && ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) rdy[i] = ($urandom_range(3) != 0);
      cycle(1'b1, av, {$urandom, $urandom, $urandom, $urandom}, rdy);
      chk("rand_no_err", 64'(obs_err), 64'd0);
    end
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, '0, 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
